// File: rtl/fb_writer.sv
// Framebuffer write engine: turns SETXY/PIXEL/CLEAR commands into byte writes at y*WIDTH+x.
// Optional macro FB_VBLANK_WRITE_EN restricts all writes to the vertical-sync window.
module fb_writer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 100,
  parameter int ADDR_W = 32
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [1:0]        i_Cmd,
  input  logic [7:0]        i_X,
  input  logic [7:0]        i_Y,
  input  logic [7:0]        i_Data,
  input  logic              i_VS,
  output logic [ADDR_W-1:0] o_WrAddr,
  output logic [7:0]        o_WrData,
  output logic              o_WrEn,
  output logic              o_Busy,
  output logic              o_Err
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TOTAL);
  localparam logic [7:0]        X_MAX    = 8'(WIDTH - 1);
  localparam logic [7:0]        Y_MAX    = 8'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

  localparam logic [1:0] CMD_SETXY = 2'b00;
  localparam logic [1:0] CMD_PIXEL = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          x_reg, x_next;
  logic [7:0]          y_reg, y_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [7:0]          fill_reg, fill_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          data_reg, data_next;
  logic                wren_reg, wren_next;
  logic                busy_reg, busy_next;
  logic                err_reg, err_next;

  logic                vs_ok;
  logic                accept;
  logic                xy_in_range;
  logic [ADDR_W-1:0]   pix_addr;

`ifdef FB_VBLANK_WRITE_EN
  assign vs_ok = i_VS;
`else
  logic unused_vs;
  assign unused_vs = i_VS;
  assign vs_ok     = 1'b1;
`endif

  assign o_Ready     = (state_reg == ST_IDLE) && vs_ok;
  assign accept      = i_Valid && o_Ready;
  assign xy_in_range = (32'(i_X) < WIDTH) && (32'(i_Y) < HEIGHT);
  assign pix_addr    = ADDR_W'(y_reg) * WIDTH_A + ADDR_W'(x_reg);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    fill_next  = fill_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wren_next  = 1'b0;
    busy_next  = busy_reg;
    err_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (i_Cmd)
            CMD_SETXY: begin
              if (xy_in_range) begin
                x_next = i_X;
                y_next = i_Y;
              end else begin
                err_next = 1'b1;
              end
            end
            CMD_PIXEL: begin
              addr_next = pix_addr;
              data_next = i_Data;
              wren_next = 1'b1;
              if (x_reg == X_MAX) begin
                x_next = 8'd0;
                y_next = (y_reg == Y_MAX) ? 8'd0 : y_reg + 8'd1;
              end else begin
                x_next = x_reg + 8'd1;
              end
            end
            CMD_CLEAR: begin
              // First fill write goes out on the accepting edge; counter tracks the next address.
              state_next = ST_CLEAR;
              busy_next  = 1'b1;
              fill_next  = i_Data;
              addr_next  = '0;
              data_next  = i_Data;
              wren_next  = 1'b1;
              cnt_next   = CNT_W'(1);
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        if (cnt_reg == LAST_CNT) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          x_next     = 8'd0;
          y_next     = 8'd0;
        end else if (vs_ok) begin
          addr_next = ADDR_W'(cnt_reg);
          data_next = fill_reg;
          wren_next = 1'b1;
          cnt_next  = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg <= ST_IDLE;
      x_reg     <= 8'd0;
      y_reg     <= 8'd0;
      cnt_reg   <= '0;
      fill_reg  <= 8'd0;
      addr_reg  <= '0;
      data_reg  <= 8'd0;
      wren_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      fill_reg  <= fill_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      wren_reg  <= wren_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  assign o_WrAddr = addr_reg;
  assign o_WrData = data_reg;
  assign o_WrEn   = wren_reg;
  assign o_Busy   = busy_reg;
  assign o_Err    = err_reg;

endmodule
